reg_bank_arbiter: RTL and testbench

- Two-requester round-robin arbiter in front of a small shared register bank built from resettable D flip-flops.
- Serialises read and write accesses from two masters onto one bank.
- Returns read data with a requester tag.
- Sits between lab-level stimulus/controller logic and the register-storage primitives of the register lab.

---
 rtl/reg_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small resettable register bank.
// Optional REG_ARB_LOCK_EN adds lock0/lock1 so an owner can keep the bank for atomic sequences.
module reg_bank_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
`ifdef REG_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rid,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          cmd_we_reg, cmd_we_next;
    logic [AW-1:0] cmd_addr_reg, cmd_addr_next;
    logic [DW-1:0] cmd_wdata_reg, cmd_wdata_next;
    logic [DW-1:0] rdata_reg;
    logic          rvalid_reg;
    logic          rid_reg;
    logic [DW-1:0] bank_q [DEPTH];

    logic any_req;
    logic winner;
    logic lock_hold;

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_reg;
        end else begin
            winner = req1;
        end
`ifdef REG_ARB_LOCK_EN
        // A locked owner re-requesting straight out of its own RESP keeps the bank.
        lock_hold = (state_reg == RESP) &&
                    (owner_reg ? (lock1 && req1) : (lock0 && req0));
`else
        lock_hold = 1'b0;
`endif
        if (lock_hold) begin
            winner = owner_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        cmd_we_next    = cmd_we_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_wdata_next = cmd_wdata_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (any_req) begin
                    state_next     = ACCESS;
                    owner_next     = winner;
                    if (!lock_hold) begin
                        last_next = winner;
                    end
                    cmd_we_next    = winner ? we1    : we0;
                    cmd_addr_next  = winner ? addr1  : addr0;
                    cmd_wdata_next = winner ? wdata1 : wdata0;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS:  state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            cmd_we_reg    <= cmd_we_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_wdata_reg <= cmd_wdata_next;
        end
    end

    // Each bank word is its own resettable register; writes land at the edge ending ACCESS.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
        logic [DW-1:0] word_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg <= '0;
            end else if (state_reg == ACCESS && cmd_we_reg && cmd_addr_reg == AW'(gi)) begin
                word_reg <= cmd_wdata_reg;
            end
        end
        assign bank_q[gi] = word_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            rid_reg    <= 1'b0;
        end else begin
            rvalid_reg <= (state_reg == ACCESS) && !cmd_we_reg;
            if (state_reg == ACCESS && !cmd_we_reg) begin
                rdata_reg <= bank_q[cmd_addr_reg];
                rid_reg   <= owner_reg;
            end
        end
    end

    assign gnt0   = (state_reg == ACCESS) && !owner_reg;
    assign gnt1   = (state_reg == ACCESS) &&  owner_reg;
    assign busy   = (state_reg != IDLE);
    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign rid    = rid_reg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter; lock scenario runs when REG_ARB_LOCK_EN is defined.
module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1;
    logic       lock0, lock1;
    logic [7:0] rdata;
    logic       rvalid, rid, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_g0, n_g1;
    logic exp_w;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.DW(8), .AW(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .gnt0   (gnt0),
        .req1   (req1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .gnt1   (gnt1),
`ifdef REG_ARB_LOCK_EN
        .lock0  (lock0),
        .lock1  (lock1),
`endif
        .rdata  (rdata),
        .rvalid (rvalid),
        .rid    (rid),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_access(input logic rq, input logic we, input logic [1:0] a,
                             input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        if (!rq) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        @(negedge clk);
        chk({tag, "_gnt"},   rq ? gnt1 : gnt0, 1);
        chk({tag, "_ngnt"},  rq ? gnt0 : gnt1, 0);
        chk({tag, "_busyA"}, busy, 1);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, rvalid, !we);
        chk({tag, "_busyR"},  busy, 1);
        if (!we) begin
            chk({tag, "_rdata"}, rdata, exp_rd);
            chk({tag, "_rid"},   rid, rq);
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        $display("[TB] access rq=%0d we=%0d addr=%0d wdata=%02h rdata=%02h", rq, we, a, wd, rdata);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        lock0 = 0; lock1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_gnt0", gnt0, 0);
        chk("idle_gnt1", gnt1, 0);
        chk("idle_rvalid", rvalid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rid", rid, 0);

        for (int i = 0; i < 4; i++) do_access(1'b0, 1'b0, 2'(i), 8'h00, 8'h00, $sformatf("rst_rd%0d", i));

        do_access(1'b0, 1'b1, 2'd2, 8'hA5, 8'h00, "wr_a5");
        do_access(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, "rd_a5");

        // Contention right after reset: requester 0 wins the first tie
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1; we0 = 0; addr0 = 2'd0;
        req1 = 1; we1 = 0; addr1 = 2'd1;
        @(negedge clk);
        chk("con_gnt0", gnt0, 1);
        chk("con_gnt1_lo", gnt1, 0);
        req0 = 0;
        @(negedge clk);
        chk("con_rv0", rvalid, 1);
        chk("con_rid0", rid, 0);
        chk("con_nogntR", gnt0 | gnt1, 0);
        @(negedge clk);
        chk("con_gnt1", gnt1, 1);
        chk("con_gnt0_lo", gnt0, 0);
        chk("con_rv_lo", rvalid, 0);
        req1 = 0;
        @(negedge clk);
        chk("con_rv1", rvalid, 1);
        chk("con_rid1", rid, 1);
        @(negedge clk);
        $display("[TB] contention done");

        // Fairness: both keep requesting, writing addr 3; last grant (requester 1) wins
        n_g0 = 0; n_g1 = 0; exp_w = 1'b0;
        req0 = 1; we0 = 1; addr0 = 2'd3; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 2'd3; wdata1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_gnt", i), {gnt1, gnt0}, exp_w ? 2'b10 : 2'b01);
            if (gnt0) n_g0++;
            if (gnt1) n_g1++;
            if (exp_w) req1 = 0; else req0 = 0;
            @(negedge clk);
            if (i < 7) begin
                if (exp_w) req1 = 1; else req0 = 1;
            end else begin
                req0 = 0; req1 = 0;
            end
            $display("[TB] rr grant %0d -> requester %0d", i, exp_w);
            exp_w = ~exp_w;
        end
        @(negedge clk);
        chk("rr_n0", n_g0, 4);
        chk("rr_n1", n_g1, 4);
        chk("rr_idle", busy, 0);
        do_access(1'b0, 1'b0, 2'd3, 8'h00, 8'h22, "rr_last");

        // Reset during ACCESS of a write
        do_access(1'b0, 1'b1, 2'd1, 8'h77, 8'h00, "pre_wr");
        req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 8'h3C;
        @(negedge clk);
        chk("mr_gnt1", gnt1, 1);
        req1 = 0;
        rst = 1;
        @(negedge clk);
        chk("mr_rv", rvalid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_gnt", gnt0 | gnt1, 0);
        rst = 0;
        @(negedge clk);
        chk("mr_idle", busy, 0);
        chk("mr_rv2", rvalid, 0);
        do_access(1'b0, 1'b0, 2'd1, 8'h00, 8'h00, "mr_rd");

`ifdef REG_ARB_LOCK_EN
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0 = 1; lock0 = 1; we0 = 0; addr0 = 2'd2;
        req1 = 1; we1 = 0; addr1 = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("lk%0d_gnt0", k), gnt0, 1);
            chk($sformatf("lk%0d_gnt1", k), gnt1, 0);
            req0 = 0;
            @(negedge clk);
            if (k < 2) req0 = 1; else lock0 = 0;
            $display("[TB] lock grant %0d to requester 0", k);
        end
        @(negedge clk);
        chk("lk_gnt1", gnt1, 1);
        chk("lk_gnt0_lo", gnt0, 0);
        req1 = 0;
        @(negedge clk);
        chk("lk_rid1", rid, 1);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
